// File: rtl/ama_riscv_fetch_unit.sv
// Instruction fetch stage: issues 1-cycle-latency IMEM reads into a small fetch buffer
// and feeds inst_id/pc_id to decode, honouring stall, clear and PC redirects.
module ama_riscv_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          FB_DEPTH  = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic        pc_we,
  input  logic [31:0] alu_out,
  input  logic        stall_if,
  input  logic        clear_if,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic        inst_valid_id
);

  localparam logic [1:0] PC_SEL_ALU        = 2'd1;
  localparam logic [1:0] PC_SEL_START_ADDR = 2'd2;
  localparam int         PW                = $clog2(FB_DEPTH);
  localparam int         CW                = PW + 1;
  localparam logic [CW-1:0] DEPTH_C        = CW'(FB_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          outst_q, drop_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, occ;
  logic [31:0]   fb_pc_q   [FB_DEPTH];
  logic [31:0]   fb_inst_q [FB_DEPTH];
  logic [31:0]   inst_id_q, inst_id_d, pc_id_q, pc_id_d;
  logic          valid_q, valid_d;

  logic          redirect, issue, rsp_ok, advance, pop, bypass, push;
  logic [31:0]   target;

  always_comb begin
    redirect = (pc_sel == PC_SEL_ALU) || (pc_sel == PC_SEL_START_ADDR);
    target   = (pc_sel == PC_SEL_ALU) ? alu_out : RESET_VEC;
    occ      = count_q + CW'(outst_q);
    issue    = !rst && !redirect && pc_we && (occ < DEPTH_C);
    // A response landing in the redirect cycle belongs to the old path.
    rsp_ok   = imem_rvalid && !drop_q && !redirect;
    advance  = !redirect && !stall_if && !clear_if;
    pop      = advance && (count_q != '0);
    bypass   = advance && (count_q == '0) && rsp_ok;
    push     = rsp_ok && !bypass;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inst_id_d  = inst_id_q;
    pc_id_d    = pc_id_q;
    valid_d    = valid_q;
    if (redirect) begin
      fetch_pc_d = target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inst_id_d  = NOP_INST;
      valid_d    = 1'b0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (!stall_if) begin
        if (clear_if) begin
          inst_id_d = NOP_INST;
          valid_d   = 1'b0;
        end else if (pop) begin
          inst_id_d = fb_inst_q[rd_ptr_q];
          pc_id_d   = fb_pc_q[rd_ptr_q];
          valid_d   = 1'b1;
        end else if (bypass) begin
          inst_id_d = imem_rdata;
          pc_id_d   = req_pc_q;
          valid_d   = 1'b1;
        end else begin
          inst_id_d = NOP_INST;
          valid_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_VEC;
      req_pc_q   <= RESET_VEC;
      outst_q    <= 1'b0;
      drop_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inst_id_q  <= NOP_INST;
      pc_id_q    <= RESET_VEC;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      outst_q    <= issue;
      drop_q     <= redirect;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inst_id_q  <= inst_id_d;
      pc_id_q    <= pc_id_d;
      valid_q    <= valid_d;
      assert (!(push && (count_q == DEPTH_C)));
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fb_pc_q[wr_ptr_q]   <= req_pc_q;
      fb_inst_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req      = issue;
  assign imem_addr     = fetch_pc_q[31:2];
  assign inst_id       = inst_id_q;
  assign pc_id         = pc_id_q;
  assign inst_valid_id = valid_q;

endmodule

// File: tb/tb_ama_riscv_fetch_unit.sv
// Bench for ama_riscv_fetch_unit: IMEM model with 1-cycle latency, scoreboard of
// expected {pc,inst} in program order, plus directed timing checks.
module tb_ama_riscv_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pc_we, stall_if, clear_if, imem_req, imem_rvalid, inst_valid_id;
  logic [1:0]  pc_sel;
  logic [31:0] alu_out, imem_rdata, inst_id, pc_id;
  logic [29:0] imem_addr;

  always #5 clk = ~clk;

  ama_riscv_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_we(pc_we), .alu_out(alu_out),
    .stall_if(stall_if), .clear_if(clear_if), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_id(inst_id), .pc_id(pc_id),
    .inst_valid_id(inst_valid_id)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic        pend_req = 1'b0;
  logic [29:0] pend_addr = '0;
  logic        prev_stall = 1'b0, prev_redir = 1'b0, prev_rst = 1'b1;
  logic        last_valid = 1'b0;
  logic [31:0] last_pc = 32'h0, last_inst = NOP;
  logic        s_req, s_valid;
  logic [29:0] s_addr;
  logic [31:0] s_pc, s_inst;

  function automatic logic [31:0] tag(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive IMEM response, sample outputs mid-cycle, update scoreboard.
  task automatic cycle();
    logic redir;
    ent_t e;
    imem_rvalid = pend_req;
    imem_rdata  = pend_req ? tag({pend_addr, 2'b00}) : $urandom;
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid_id;
    s_pc = pc_id; s_inst = inst_id;
    redir = (pc_sel == 2'd1) || (pc_sel == 2'd2);
    if (prev_stall && !prev_redir && !prev_rst) begin
      chk("hold_valid", {31'b0, inst_valid_id}, {31'b0, last_valid});
      chk("hold_inst", inst_id, last_inst);
      if (last_valid) chk("hold_pc", pc_id, last_pc);
    end else if (inst_valid_id) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'b0, inst_valid_id}, 32'd0);
        last_valid = 1'b0; last_inst = NOP;
      end else begin
        e = sb.pop_front();
        chk("id_pc", pc_id, e.pc);
        chk("id_inst", inst_id, e.inst);
        last_valid = 1'b1; last_pc = e.pc; last_inst = e.inst;
      end
    end else begin
      chk("id_nop", inst_id, NOP);
      last_valid = 1'b0; last_inst = NOP;
    end
    if (rst || redir) sb.delete();
    else if (imem_rvalid) sb.push_back('{pc: {pend_addr, 2'b00}, inst: imem_rdata});
    pend_req   = imem_req;
    pend_addr  = imem_addr;
    prev_stall = stall_if;
    prev_redir = redir;
    prev_rst   = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_check(input logic [31:0] tgt, input string name);
    cycle();
    chk({name, "_req_t"}, {31'b0, s_req}, 32'd0);
    pc_sel = 2'd0; stall_if = 1'b0; clear_if = 1'b0;
    cycle();
    chk({name, "_addr_t1"}, {2'b0, s_addr}, {2'b0, tgt[31:2]});
    chk({name, "_req_t1"}, {31'b0, s_req}, 32'd1);
    cycle();
    chk({name, "_vld_t2"}, {31'b0, s_valid}, 32'd0);
    cycle();
    chk({name, "_vld_t3"}, {31'b0, s_valid}, 32'd1);
    chk({name, "_pc_t3"}, s_pc, tgt);
  endtask

  initial begin
    int nreq;
    rst = 1'b1; pc_we = 1'b0; stall_if = 1'b0; clear_if = 1'b0;
    pc_sel = 2'd0; alu_out = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    cycle(); cycle();
    chk("rst_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_inst", s_inst, NOP);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_req", {31'b0, s_req}, 32'd0);

    // Reset release and back-to-back stream
    rst = 1'b0; pc_we = 1'b1;
    cycle();
    chk("c1_req", {31'b0, s_req}, 32'd1);
    chk("c1_addr", {2'b0, s_addr}, 32'd0);
    cycle();
    chk("c2_valid", {31'b0, s_valid}, 32'd0);
    chk("c2_addr", {2'b0, s_addr}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("c3_valid", {31'b0, s_valid}, 32'd1);
      chk("c3_pc", s_pc, 32'(i * 4));
      chk("c3_req", {31'b0, s_req}, 32'd1);
    end

    // Stall for 4 cycles
    cycle();
    nreq = int'(s_req);
    stall_if = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      nreq += int'(s_req);
    end
    chk("stall_reqs", 32'(nreq), 32'd2);
    chk("stall_req_off", {31'b0, s_req}, 32'd0);
    stall_if = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // Redirect with a response in flight
    pc_sel = 2'd1; alu_out = 32'h100;
    redirect_check(32'h100, "redir");
    for (int i = 0; i < 3; i++) cycle();

    // Single-cycle clear
    clear_if = 1'b1;
    cycle();
    clear_if = 1'b0;
    cycle();
    chk("clr_valid", {31'b0, s_valid}, 32'd0);
    chk("clr_inst", s_inst, NOP);
    cycle();
    chk("clr_next_valid", {31'b0, s_valid}, 32'd1);
    for (int i = 0; i < 4; i++) cycle();

    // Redirect together with stall and clear
    pc_sel = 2'd1; alu_out = 32'h200; stall_if = 1'b1; clear_if = 1'b1;
    redirect_check(32'h200, "rsc");
    for (int i = 0; i < 3; i++) cycle();

    // Mid-stream reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("mrst_valid", {31'b0, s_valid}, 32'd0);
    chk("mrst_inst", s_inst, NOP);
    chk("mrst_pc", s_pc, 32'h0);
    chk("mrst_addr", {2'b0, s_addr}, 32'd0);
    cycle(); cycle();
    chk("mrst_pc0", s_pc, 32'h0);
    chk("mrst_v0", {31'b0, s_valid}, 32'd1);

    // Redirect near the top of the address space
    pc_sel = 2'd1; alu_out = 32'hFFFF_FFF8;
    redirect_check(32'hFFFF_FFF8, "wrap");
    cycle();
    chk("wrap_pc1", s_pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc2", s_pc, 32'h0000_0000);
    chk("wrap_v2", {31'b0, s_valid}, 32'd1);

    // Mixed random controls
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      stall_if = ($urandom_range(0, 3) == 0);
      clear_if = ($urandom_range(0, 7) == 0);
      pc_we    = ($urandom_range(0, 5) != 0);
      pc_sel   = (r < 4) ? 2'd1 : (r < 6) ? 2'd2 : 2'd0;
      alu_out  = $urandom & 32'hFFFF_FFFC;
      cycle();
    end

    // Drain: every accepted response must have reached ID
    pc_we = 1'b0; stall_if = 1'b0; clear_if = 1'b0; pc_sel = 2'd0;
    for (int i = 0; i < 6; i++) cycle();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
